// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - mode encodings and mode helpers shared by the LED controller
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        next_mode = MODE_OFF;
        case (m)
            MODE_OFF:  next_mode = MODE_SLOW;
            MODE_SLOW: next_mode = MODE_FAST;
            MODE_FAST: next_mode = MODE_ON;
            MODE_ON:   next_mode = MODE_OFF;
        endcase
    endfunction

    // LED level loaded on entering a mode: dark only in OFF
    function automatic logic entry_led(input mode_e m);
        return (m != MODE_OFF);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debounce counter and press-edge detector
module btn_debounce #(
    parameter int DEB_TC = 65535
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Btn,
    output logic press
);

    localparam logic [15:0] DEB_TC_W = 16'(DEB_TC);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_stable;
    logic        r_stable_d;
    logic [15:0] r_cnt;

    // Stable level only flips after DEB_TC+1 consecutive differing samples
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= 16'd0;
        end else begin
            r_sync1    <= Btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= 16'd0;
            end else if (r_cnt == DEB_TC_W) begin
                r_stable <= r_sync2;
                r_cnt    <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/blink_mode_ctrl.sv
// rtl/blink_mode_ctrl.sv - four-mode LED controller: press-stepped FSM, prescaler, LED and tick
module blink_mode_ctrl
    import blink_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int DEB_TC  = 65535,
    parameter int SLOW_TC = 16777215,
    parameter int FAST_TC = 4194303
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Btn,
    output logic       Led,
    output logic [1:0] Mode,
    output logic       Tick
);

    localparam logic [CNT_W-1:0] SLOW_TC_W = CNT_W'(SLOW_TC);
    localparam logic [CNT_W-1:0] FAST_TC_W = CNT_W'(FAST_TC);

    mode_e            r_mode;
    mode_e            w_mode_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_tc;
    logic             r_led;
    logic             w_led_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             w_press;

    btn_debounce #(
        .DEB_TC (DEB_TC)
    ) u_btn_debounce (
        .Clk   (Clk),
        .Rst   (Rst),
        .Btn   (Btn),
        .press (w_press)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_mode <= MODE_OFF;
            r_cnt  <= '0;
            r_led  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_cnt  <= w_cnt_nxt;
            r_led  <= w_led_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    // A press overrides a coincident terminal count: no toggle, prescaler restarts
    always_comb begin
        w_mode_nxt = r_mode;
        w_cnt_nxt  = '0;
        w_led_nxt  = r_led;
        w_tick_nxt = 1'b0;
        w_tc       = (r_mode == MODE_FAST) ? FAST_TC_W : SLOW_TC_W;
        if (w_press) begin
            w_mode_nxt = next_mode(r_mode);
            w_led_nxt  = entry_led(next_mode(r_mode));
        end else if (r_mode == MODE_SLOW || r_mode == MODE_FAST) begin
            if (r_cnt == w_tc) begin
                w_led_nxt  = ~r_led;
                w_tick_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    assign Mode = r_mode;
    assign Led  = r_led;
    assign Tick = r_tick;

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// tb/tb_blink_mode_ctrl.sv - self-checking bench for blink_mode_ctrl
module tb_blink_mode_ctrl;

    localparam int CNT_W   = 8;
    localparam int DEB_TC  = 3;
    localparam int SLOW_TC = 9;
    localparam int FAST_TC = 3;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Btn = 1'b0;
    logic       Led;
    logic [1:0] Mode;
    logic       Tick;

    int n_checks = 0;
    int n_errors = 0;

    blink_mode_ctrl #(
        .CNT_W   (CNT_W),
        .DEB_TC  (DEB_TC),
        .SLOW_TC (SLOW_TC),
        .FAST_TC (FAST_TC)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Btn  (Btn),
        .Led  (Led),
        .Mode (Mode),
        .Tick (Tick)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: Btn sample history, stable level, mode, and edges since last mode change
    bit hist[$];
    bit m_stable = 1'b0;
    bit m_rise   = 1'b0;
    int m_mode   = 0;
    int m_k      = 0;

    function automatic bit old_sample(input int idx);
        return (idx < hist.size()) ? hist[idx] : 1'b0;
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hist.delete();
            m_stable = 1'b0;
            m_rise   = 1'b0;
            m_mode   = 0;
            m_k      = 0;
        end else begin
            bit all_diff;
            bit old_stable;
            all_diff = 1'b1;
            // The debouncer at this edge sees the Btn samples taken 2..DEB_TC+2 edges ago
            for (int j = 0; j <= DEB_TC; j++)
                if (old_sample(1 + j) == m_stable) all_diff = 1'b0;
            if (m_rise) begin
                m_mode = (m_mode + 1) % 4;
                m_k    = 0;
            end else begin
                m_k++;
            end
            old_stable = m_stable;
            if (all_diff) m_stable = !m_stable;
            m_rise = m_stable && !old_stable;
            hist.push_front(Btn);
            if (hist.size() > DEB_TC + 4) void'(hist.pop_back());
        end
    end

    function automatic int exp_led();
        int tc;
        if (m_mode == 0) return 0;
        if (m_mode == 3) return 1;
        tc = (m_mode == 1) ? SLOW_TC : FAST_TC;
        return 1 ^ ((m_k / (tc + 1)) & 1);
    endfunction

    function automatic int exp_tick();
        int tc;
        if (m_mode == 0 || m_mode == 3) return 0;
        tc = (m_mode == 1) ? SLOW_TC : FAST_TC;
        return (m_k > 0 && (m_k % (tc + 1)) == 0) ? 1 : 0;
    endfunction

    always @(negedge Clk) begin
        if (Rst) begin
            chk("model_mode", int'(Mode), m_mode);
            chk("model_led", int'(Led), exp_led());
            chk("model_tick", int'(Tick), exp_tick());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    int  t1_ticks;
    bit  found;
    int  exp_modes[4] = '{1, 2, 3, 0};
    int  exp_leds[4]  = '{1, 1, 1, 0};

    initial begin
        // 1: reset release with button idle
        step(2);
        chk("reset_mode", int'(Mode), 0);
        chk("reset_led", int'(Led), 0);
        chk("reset_tick", int'(Tick), 0);
        Rst = 1'b1;
        t1_ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (Tick) t1_ticks++;
        end
        chk("t1_mode", int'(Mode), 0);
        chk("t1_led", int'(Led), 0);
        chk("t1_tick_count", t1_ticks, 0);

        // 2: clean press, first sampled at edge E
        Btn = 1'b1;
        step(6);
        chk("t2_mode_before", int'(Mode), 0);
        step(1);
        chk("t2_mode_e6", int'(Mode), 1);
        chk("t2_led_e6", int'(Led), 1);
        step(10);
        chk("t2_led_e16", int'(Led), 0);
        chk("t2_tick_e16", int'(Tick), 1);
        step(1);
        chk("t2_tick_e17", int'(Tick), 0);
        step(9);
        chk("t2_led_e26", int'(Led), 1);
        chk("t2_tick_e26", int'(Tick), 1);
        Btn = 1'b0;
        step(12);

        // 3: bounce of 2-high/2-low pulses
        for (int i = 0; i < 5; i++) begin
            Btn = 1'b1;
            step(2);
            Btn = 1'b0;
            step(2);
        end
        step(20);
        chk("t3_mode", int'(Mode), 1);

        // 4: mode cycling from OFF after a reset pulse
        Rst = 1'b0;
        step(2);
        chk("t4_reset_mode", int'(Mode), 0);
        Rst = 1'b1;
        step(5);
        for (int i = 0; i < 4; i++) begin
            Btn = 1'b1;
            step(10);
            chk("t4_mode", int'(Mode), exp_modes[i]);
            chk("t4_led", int'(Led), exp_leds[i]);
            Btn = 1'b0;
            step(30);
        end

        // 5: press lands on the SLOW terminal count (20 edges after entering SLOW)
        Btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (Mode == 2'd1) found = 1'b1;
        end
        chk("t5_enter_slow", int'(found), 1);
        Btn = 1'b0;
        step(13);
        Btn = 1'b1;
        step(6);
        chk("t5_mode_m19", int'(Mode), 1);
        chk("t5_led_m19", int'(Led), 0);
        step(1);
        chk("t5_mode_m20", int'(Mode), 2);
        chk("t5_led_m20", int'(Led), 1);
        chk("t5_tick_m20", int'(Tick), 0);
        Btn = 1'b0;
        step(4);
        chk("t5_led_m24", int'(Led), 0);
        chk("t5_tick_m24", int'(Tick), 1);

        // 6: asynchronous reset between edges while in FAST
        step(1);
        Rst = 1'b0;
        #1;
        chk("t6_mode", int'(Mode), 0);
        chk("t6_led", int'(Led), 0);
        chk("t6_tick", int'(Tick), 0);
        step(2);
        Rst = 1'b1;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/blink_mode_ctrl.md
# blink_mode_ctrl

Controller for the board's single LED channel. It turns the raw push-button into a debounced press pulse, steps a four-mode state machine on each press, and owns a prescaler counter. In blinking modes the prescaler's terminal count toggles the LED. It sits directly between the board pins (`btn`, `Led`) and replaces the free-running counter that currently drives `Led` straight.

## Interface
Parameters:
- `CNT_W`, 24: prescaler width in bits.
- `DEB_TC`, 65535: debounce terminal count. It must fit in 16 bits.
- `SLOW_TC`, 16777215: prescaler terminal count in SLOW mode. It must be less than 2^CNT_W.
- `FAST_TC`, 4194303: prescaler terminal count in FAST mode. It must be less than 2^CNT_W.

Ports (one clock; reset is asynchronous and active-low):
- `Clk`  in  1  system clock; all state is updated on its rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Btn`  in  1  raw, asynchronous, bouncing push-button; high means pressed.
- `Led`  out 1  registered LED drive.
- `Mode` out 2  current mode: 0 = OFF, 1 = SLOW, 2 = FAST, 3 = ON.
- `Tick` out 1  registered one-cycle pulse, asserted on each prescaler terminal count that toggles `Led`.

## Operation
- **Reset values:** `Led`=0, `Mode`=OFF, `Tick`=0. Synchronizer flops, the stable button level, the debounce counter and the prescaler are all 0.
- **Synchronizer:** `Btn` passes through a 2-flop synchronizer to give `btn_s`.
- **Debounce counter (16 bit):**
  - If `btn_s` equals `btn_stable`, the counter clears to 0.
  - Otherwise it increments.
  - When it equals `DEB_TC` while `btn_s` still differs, then on the next edge `btn_stable` takes `btn_s` and the counter clears.
- **Press pulse:** `press` = `btn_stable` AND NOT (`btn_stable` delayed one cycle). Releases never generate a press.
- **Mode FSM:** each press steps the mode OFF→SLOW→FAST→ON→OFF. There are no other transitions.
- **On any mode change:** the prescaler clears to 0, `Tick`=0, and `Led` is loaded with the entry value: OFF gives 0; SLOW, FAST and ON give 1.
- **OFF and ON modes:** the prescaler is held at 0, `Tick` stays 0, and `Led` holds its entry value.
- **SLOW and FAST modes:**
  - The prescaler increments every cycle.
  - When it equals the current mode's terminal count (TC), it wraps to 0, `Led` toggles and `Tick`=1 for that one cycle.
- **Simultaneous press and terminal count:** the mode change wins. No toggle occurs, `Tick` stays 0 and the prescaler clears.
- **TC = 0:** `Led` toggles and `Tick` is asserted every cycle.
- **Btn held high through reset release:** after debounce this is treated as a press, so the mode becomes SLOW.
- **Reset asserted mid-operation:** all state returns to reset values immediately, without waiting for `Clk`.

## Timing
- **Press latency:** `Mode` changes on the (DEB_TC+3)th rising edge after the first edge that samples `Btn`=1. This assumes `Btn` stays high and clean from that edge onward.
- **Glitch rejection:** a `Btn` pulse shorter than DEB_TC+1 cycles, as seen at `btn_s`, produces no press.
- **Blink rate:** in SLOW/FAST, the first toggle comes TC+1 cycles after the mode-change edge, and subsequent toggles come every TC+1 cycles. The full LED period is 2·(TC+1) cycles.
- **Tick alignment:** `Tick` is high in exactly the cycle following the edge on which `Led` toggled.

## Structure
- **Shared package `blink_pkg`:**
  - Mode encodings `MODE_OFF`, `MODE_SLOW`, `MODE_FAST`, `MODE_ON`, each 2 bits.
  - A next-mode function.
  - The entry-LED-value function.
- **Sub-module `btn_debounce`:** contains the synchronizer, debounce counter and press-edge detector. Its parameter is `DEB_TC`; its ports are `Clk`, `Rst`, `Btn` and `press`.
- **Kept in the top:** the FSM, prescaler and LED/`Tick` registers.

## Test plan
Bench parameters: `CNT_W`=8, `DEB_TC`=3, `SLOW_TC`=9, `FAST_TC`=3.
1. **Reset release:** release `Rst` with `Btn`=0 and run 50 cycles → `Mode`=0, `Led`=0, `Tick` never asserted.
2. **Clean press:** hold `Btn` high from edge E → `Mode`=1 at edge E+6 with `Led`=1. `Led` toggles at E+16, E+26 and so on; `Tick` is high in each following cycle.
3. **Bounce:** apply 2-cycle high pulses separated by 2-cycle lows for 20 cycles, then hold low → `Mode` unchanged.
4. **Mode cycling:** give four clean presses, each held 10 cycles with 30-cycle gaps → `Mode` goes 1, 2, 3, 0. In FAST, `Led` toggles every 4 cycles; in ON, `Led`=1 constant; in OFF, `Led`=0.
5. **Press on terminal count:** align a press so the mode-change edge coincides with prescaler=9 in SLOW → `Mode`=2, `Led`=1, no `Tick`, prescaler=0.
6. **Asynchronous reset mid-blink:** assert `Rst`=0 between clock edges while in FAST → `Mode`=0, `Led`=0, `Tick`=0 immediately, before the next `Clk` edge.
